// File: rtl/infer_ctrl_pkg.sv
// infer_ctrl shared types and constants.
// State encoding, default frame length and ASCII reply codes.
package infer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    REPLY
  } infer_state_t;

  localparam int FRAME_LEN_DEF = 784;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  function automatic logic [7:0] digit_ascii(
    input logic [3:0] d
  );
    return (d <= 4'd9) ? (ASCII_ZERO + {4'd0, d})
                       : ASCII_QMARK;
  endfunction

endpackage

// File: rtl/infer_ctrl_rise.sv
// rise_detect: registered rising-edge detector.
// Edge is high while the input is high and its last sample was low.
module rise_detect (
  input  logic clk,
  input  logic nRST,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) r_prev <= 1'b0;
    else       r_prev <= i_sig;
  end

  assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/infer_ctrl.sv
// infer_ctrl: UART frame loader / net_proc sequencer / result reply.
// Optional inter-byte timeout in LOAD: define INFER_CTRL_TIMEOUT_EN.
module infer_ctrl
  import infer_ctrl_pkg::*;
#(
  parameter int FRAME_LEN   = FRAME_LEN_DEF,
  parameter int TIMEOUT_CYC = 10_000_000
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_error,
  output logic       mem_rst,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  output logic       net_start,
  input  logic       net_done,
  input  logic [3:0] net_result,
  output logic       tx_rq,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic [3:0] result_q
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_M1 = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] FULL    = CW'(FRAME_LEN);

  infer_state_t  r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          r_we1, r_last1, r_last2;
  logic          w_byte, w_done;
  logic          w_idle, w_load, w_run, w_reply;
  logic          w_abort, w_accept, w_go, w_tmo;

  rise_detect u_rx_rise (
    .clk    (clk),
    .nRST   (nRST),
    .i_sig  (rx_ready),
    .o_rise (w_byte)
  );

  rise_detect u_done_rise (
    .clk    (clk),
    .nRST   (nRST),
    .i_sig  (net_done),
    .o_rise (w_done)
  );

  assign w_idle  = (r_state == IDLE);
  assign w_load  = (r_state == LOAD);
  assign w_run   = (r_state == RUN);
  assign w_reply = (r_state == REPLY);

  // an error in LOAD wins over a byte arriving in the same cycle
  assign w_abort  = w_load & rx_error;
  assign w_accept = w_byte & (w_idle | (w_load & ~rx_error));
  assign w_go     = w_load & mem_we & r_last2 & ~rx_error & ~w_tmo;

`ifdef INFER_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_idle;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST)                r_idle <= '0;
    else if (!w_load || w_byte) r_idle <= '0;
    else                      r_idle <= r_idle + 1'b1;
  end

  assign w_tmo = w_load & ~w_byte &
                 (r_idle == TW'(TIMEOUT_CYC - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_byte) w_next = LOAD;
      LOAD: begin
        if (w_abort || w_tmo) w_next = IDLE;
        else if (w_go)        w_next = RUN;
      end
      RUN:     if (w_done)   w_next = REPLY;
      REPLY:   if (!tx_busy) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_cnt     <= '0;
      r_we1     <= 1'b0;
      r_last1   <= 1'b0;
      r_last2   <= 1'b0;
      mem_rst   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      net_start <= 1'b0;
      tx_rq     <= 1'b0;
      tx_data   <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      result_q  <= '0;
    end else begin
      mem_rst   <= w_idle & w_byte;
      r_we1     <= w_accept;
      r_last1   <= w_accept & w_load & (r_cnt == LAST_M1);
      mem_we    <= r_we1;
      r_last2   <= r_last1;
      net_start <= w_go;
      tx_rq     <= w_reply & ~tx_busy;
      if (w_accept) mem_wdata <= rx_data;
      if (w_idle && w_byte)
        r_cnt <= CW'(1);
      else if (w_abort || w_tmo)
        r_cnt <= '0;
      else if (w_accept && w_load && r_cnt != FULL)
        r_cnt <= r_cnt + 1'b1;
      if (w_idle && w_byte)      frame_err <= 1'b0;
      else if (w_abort || w_tmo) frame_err <= 1'b1;
      if (w_byte && (w_run || w_reply)) overrun <= 1'b1;
      if (w_run && w_done) result_q <= net_result;
      if (w_reply && !tx_busy) tx_data <= digit_ascii(result_q);
    end
  end

  assign busy = ~w_idle;

endmodule

// File: tb/tb_infer_ctrl.sv
// tb_infer_ctrl: scoreboard on memory writes plus result table.
// Timeout sequence runs only when INFER_CTRL_TIMEOUT_EN is defined.
module tb_infer_ctrl;
  import infer_ctrl_pkg::*;

  localparam int FL = 784;

  logic       clk = 1'b0;
  logic       nRST = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_error = 1'b0;
  logic       net_done = 1'b0;
  logic [3:0] net_result = '0;
  logic       tx_busy = 1'b0;
  logic       mem_rst, mem_we, net_start, tx_rq;
  logic       busy, frame_err, overrun;
  logic [7:0] mem_wdata, tx_data;
  logic [3:0] result_q;

  infer_ctrl #(.FRAME_LEN(FL), .TIMEOUT_CYC(1000)) dut (
    .clk(clk), .nRST(nRST),
    .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_error(rx_error),
    .mem_rst(mem_rst), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .net_start(net_start),
    .net_done(net_done), .net_result(net_result),
    .tx_rq(tx_rq), .tx_data(tx_data),
    .tx_busy(tx_busy), .busy(busy),
    .frame_err(frame_err), .overrun(overrun),
    .result_q(result_q)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  int rst_cnt = 0, we_cnt = 0, start_cnt = 0, tx_cnt = 0;
  int rst_cyc = 0, we_cyc = 0, start_cyc = 0, tx_cyc = 0;
  logic [7:0] tx_seen = '0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (nRST) begin
      if (mem_rst) begin
        rst_cnt++;
        rst_cyc = cyc;
      end
      if (mem_we) begin
        we_cnt++;
        we_cyc = cyc;
        if (exp_q.size() == 0) chk("we_unexpected", 1, 0);
        else chk("mem_wdata", {24'd0, mem_wdata},
                 {24'd0, exp_q.pop_front()});
      end
      if (net_start) begin
        start_cnt++;
        start_cyc = cyc;
      end
      if (tx_rq) begin
        tx_cnt++;
        tx_cyc = cyc;
        tx_seen = tx_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input bit wr);
    if (wr) exp_q.push_back(b);
    rx_data = b;
    rx_ready = 1'b1;
    tick();
    tick();
    rx_ready = 1'b0;
    tick();
  endtask

  task automatic load_bytes(input int n);
    int r0, s;
    r0 = rst_cnt;
    s = cyc;
    for (int i = 0; i < n; i++) begin
      send_byte(8'(i), 1'b1);
      if (i == 0) begin
        chk("mem_rst_cnt", rst_cnt, r0 + 1);
        chk("mem_rst_lat", rst_cyc, s + 1);
        chk("mem_we_lat", we_cyc, s + 2);
        chk("frame_err_clr", {31'd0, frame_err}, 0);
      end
    end
  endtask

  task automatic load_frame();
    int st0, w0;
    st0 = start_cnt;
    w0 = we_cnt;
    load_bytes(FL);
    for (int k = 0; k < 10 && start_cnt == st0; k++)
      @(negedge clk);
    chk("net_start_cnt", start_cnt, st0 + 1);
    chk("net_start_lat", start_cyc, we_cyc + 1);
    chk("we_cnt", we_cnt, w0 + FL);
    chk("q_empty", exp_q.size(), 0);
    chk("busy_run", {31'd0, busy}, 1);
    tick();
  endtask

  task automatic do_done(input logic [3:0] res,
                         input logic [7:0] exp,
                         input int bcyc);
    int t0, d;
    t0 = tx_cnt;
    net_result = res;
    tx_busy = (bcyc > 0);
    net_done = 1'b1;
    d = cyc;
    if (bcyc > 0) begin
      tick();
      repeat (bcyc) tick();
      chk("tx_held", tx_cnt, t0);
      tx_busy = 1'b0;
      d = cyc - 1;
    end
    for (int k = 0; k < 20 && tx_cnt == t0; k++)
      @(negedge clk);
    chk("tx_cnt", tx_cnt, t0 + 1);
    chk("tx_lat", tx_cyc, d + 2);
    chk("tx_data", {24'd0, tx_seen}, {24'd0, exp});
    chk("result_q", {28'd0, result_q}, {28'd0, res});
    chk("busy_idle", {31'd0, busy}, 0);
    tick();
    net_done = 1'b0;
    tick();
    chk("tx_data_hold", {24'd0, tx_data}, {24'd0, exp});
    chk("tx_rq_pulse", {31'd0, tx_rq}, 0);
  endtask

  typedef struct {
    logic [3:0] res;
    logic [7:0] exp;
    int         bcyc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int st0, w0, t0;
    vecs[0] = '{4'd7,  8'h37, 0};
    vecs[1] = '{4'd12, 8'h3F, 0};
    vecs[2] = '{4'd0,  8'h30, 0};
    vecs[3] = '{4'd9,  8'h39, 50};
    vecs[4] = '{4'd10, 8'h3F, 0};
    vecs[5] = '{4'd15, 8'h3F, 0};

    repeat (3) tick();
    chk("reset_outs",
        {5'd0, mem_rst, mem_we, mem_wdata, net_start, tx_rq,
         tx_data, busy, frame_err, overrun, result_q}, 0);
    nRST = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      load_frame();
      do_done(vecs[i].res, vecs[i].exp, vecs[i].bcyc);
    end
    chk("no_overrun", {31'd0, overrun}, 0);

    st0 = start_cnt;
    load_bytes(300);
    rx_error = 1'b1;
    tick();
    rx_error = 1'b0;
    tick();
    chk("abort_err", {31'd0, frame_err}, 1);
    chk("abort_idle", {31'd0, busy}, 0);
    repeat (20) tick();
    chk("abort_nostart", start_cnt, st0);
    chk("abort_q", exp_q.size(), 0);
    load_frame();
    do_done(4'd3, 8'h33, 0);
    chk("err_cleared", {31'd0, frame_err}, 0);

    net_done = 1'b1;
    load_frame();
    w0 = we_cnt;
    t0 = tx_cnt;
    send_byte(8'hAA, 1'b0);
    repeat (3) tick();
    chk("overrun_set", {31'd0, overrun}, 1);
    chk("overrun_nowe", we_cnt, w0);
    repeat (20) tick();
    chk("stale_done_run", {31'd0, busy}, 1);
    chk("stale_done_notx", tx_cnt, t0);
    net_done = 1'b0;
    tick();
    do_done(4'd5, 8'h35, 0);

    load_frame();
    nRST = 1'b0;
    #1;
    chk("mid_reset_outs",
        {5'd0, mem_rst, mem_we, mem_wdata, net_start, tx_rq,
         tx_data, busy, frame_err, overrun, result_q}, 0);
    tick();
    nRST = 1'b1;
    tick();
    tick();
    chk("post_reset_idle", {31'd0, busy}, 0);

`ifdef INFER_CTRL_TIMEOUT_EN
    load_bytes(10);
    repeat (900) tick();
    chk("tmo_early", {31'd0, frame_err}, 0);
    chk("tmo_load", {31'd0, busy}, 1);
    for (int k = 0; k < 200 && !frame_err; k++) tick();
    chk("tmo_err", {31'd0, frame_err}, 1);
    chk("tmo_idle", {31'd0, busy}, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
